master_rx_port: RTL
===================

Name: master_rx_port

Overview:
Next-generation master-side serial receive port for the serial system bus. It captures words from one or more serial data lanes after a per-word valid/ready handshake with the slave. It supports single-read and burst-read instructions and selectable bit order. Received words are buffered in an internal FIFO and presented to the master core over a valid/ready interface, so the core can stall without losing bus data.

Parameters:
WORD_SIZE, 8, bits per word; must be a multiple of LANES
BURST_W, 15, width of burst_size
LANES, 1, number of parallel serial data lanes (1, 2, 4 or 8)
FIFO_DEPTH, 4, receive FIFO depth in words; power of 2, at least 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_data  in  LANES  serial data from the bus; lane j is bit j
s_valid  in  1  slave has a word ready to shift
m_ready  out  1  master can accept a word (handshake)
instruction  in  3  core command; 3'b001 = single read, 3'b011 = burst read, others = no-op
burst_size  in  BURST_W  words in a burst read; sampled at start
msb_first  in  1  bit order; 0 = LSB first, 1 = MSB first; sampled at start
s_data  out  WORD_SIZE  FIFO head word
new_data  out  1  s_data valid (FIFO not empty)
core_ready  in  1  core accepts s_data
rx_done  out  1  one-cycle pulse when the last word of the transaction is written to the FIFO
busy  out  1  transaction in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On reset:
  - state = IDLE; all counters = 0; FIFO emptied.
  - m_ready = 0, rx_done = 0, busy = 0, new_data = 0, s_data = 0.
  - Reset mid-transaction aborts it; any partial word is discarded.
- Beats and bit mapping: BEATS = WORD_SIZE/LANES beats per word.
  - LSB first: beat k, lane j -> bit k*LANES + j.
  - MSB first: beat k, lane j -> bit WORD_SIZE - LANES*(k+1) + j.
- Internal state: registered states IDLE, WAIT, SHIFT, DONE.
- IDLE:
  - On instruction 3'b001: latch words_left = 1, go to WAIT.
  - On instruction 3'b011: latch words_left = burst_size, go to WAIT.
  - msb_first is latched in both cases.
  - Burst read with burst_size = 0: go to DONE directly; no handshake occurs.
  - Instruction changes while busy are ignored.
- WAIT:
  - m_ready = 1 exactly when FIFO count < FIFO_DEPTH; otherwise 0.
  - A cycle with m_ready && s_valid is the handshake; go to SHIFT.
  - m_ready drops in the cycle after the handshake.
- SHIFT:
  - Sample rx_data on each of the next BEATS cycles; beat 0 is the first cycle after the handshake.
  - On the last beat the assembled word is pushed into the FIFO at that clock edge, and words_left is decremented.
  - If words_left was 1, go to DONE; otherwise go to WAIT.
  - The next handshake is possible at the earliest in the cycle after the push.
- DONE: rx_done = 1 for exactly one cycle, then go to IDLE.
  - rx_done does not wait for the FIFO to drain.
- FIFO:
  - First-word fall-through: new_data = count != 0, and s_data = head word.
  - Pop when new_data && core_ready.
  - Push and pop in the same cycle leave count unchanged.
  - No overflow is possible: space is reserved at handshake, since only one word is in flight and count cannot grow during SHIFT.
  - When empty, s_data holds its last value (0 after reset).
- Latency: last beat at cycle N -> word in FIFO at the N edge -> new_data = 1 in cycle N+1 if the FIFO was empty.
- Counters: burst counter is BURST_W bits wide; maximum burst is 2^BURST_W - 1 words. Beat counter is $clog2(BEATS) bits wide; it wraps to 0 after each word.

Decomposition:
- Package serial_bus_pkg:
  - Instruction constants INSTR_READ = 3'b001 and INSTR_BURST_READ = 3'b011.
  - rx_state_t enum {IDLE, WAIT, SHIFT, DONE}.
- One sub-module: sync_fifo, parameters WIDTH and DEPTH, with push, pop, full, empty and count.
  - Shared with the future master transmit port.

Test Plan:
1. LANES=1, LSB first, single read. Handshake, then beats 1,0,1,1,0,0,1,0 -> s_data = 8'h4D and new_data in the cycle after the last beat; rx_done pulses once; busy drops after DONE.
2. Same stimulus with msb_first = 1 -> s_data = 8'hB2.
3. LANES=2, LSB first, single read. rx_data beats 2'b01, 2'b11, 2'b00, 2'b10 -> s_data = 8'h8D after 4 beats.
4. FIFO_DEPTH=2, burst_size=3, core_ready=0.
   - After 2 words, m_ready stays 0 despite s_valid = 1.
   - Raise core_ready -> m_ready rises in the cycle after the first pop; the third word is received; rx_done pulses.
   - Words pop in order.
5. Assert rst mid-SHIFT of word 2 of a 4-word burst -> all outputs read 0 immediately; FIFO empty; a following single read completes normally.
6. Burst read with burst_size = 0 -> m_ready never rises; rx_done pulses one cycle after the instruction; new_data stays 0.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial system bus ports: core instruction
// codes, the receive-port state type and small sizing helpers.
package serial_bus_pkg;

    // Core instruction codes; every other code is a no-op
    localparam logic [2:0] INSTR_READ       = 3'b001;
    localparam logic [2:0] INSTR_BURST_READ = 3'b011;

    // Receive-port controller states
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        DONE
    } rx_state_t;

    // A counter for n values needs clog2(n) bits, but never less than one
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO. The head word is always visible
// on head_o while the FIFO is not empty. A push is dropped when the FIFO is full
// unless a pop happens in the same cycle. A pop is ignored when the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage write; the contents only matter where count says they are valid
    // NOTE: the storage array has no reset. Its contents are qualified by the
    // pointers and count, which are reset. Resetting the array would only add a
    // reset fan-out to every storage bit and would block RAM inference.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the values from before the edge, whatever the order of the
    // statements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/master_rx_port.sv
// Master-side serial receive port. For each word it does a valid/ready
// handshake with the slave, then shifts the word in over BEATS cycles on LANES
// parallel lanes, in either bit order, and pushes it into a receive FIFO. The
// core drains that FIFO over a valid/ready interface.
module master_rx_port
    import serial_bus_pkg::*;
#(
    parameter int WORD_SIZE  = 8,
    parameter int BURST_W    = 15,
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LANES-1:0]     rx_data,
    input  logic                 s_valid,
    output logic                 m_ready,
    input  logic [2:0]           instruction,
    input  logic [BURST_W-1:0]   burst_size,
    input  logic                 msb_first,
    output logic [WORD_SIZE-1:0] s_data,
    output logic                 new_data,
    input  logic                 core_ready,
    output logic                 rx_done,
    output logic                 busy
);

    localparam int BEATS  = WORD_SIZE / LANES;
    localparam int BEAT_W = counter_width(BEATS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    rx_state_t            state_q;
    logic [BURST_W-1:0]   words_left_q;
    logic [BEAT_W-1:0]    beat_q;
    logic                 msb_first_q;
    logic [WORD_SIZE-1:0] word_q;
    logic [WORD_SIZE-1:0] word_d;
    logic [WORD_SIZE-1:0] hold_q;
    int                   lane_base;
    logic                 last_beat;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [WORD_SIZE-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    // Merge the current beat into the partial word at its bit-order position
    // NOTE: every signal written here gets a default first. Otherwise a path
    // that skips the assignment would infer a latch.
    always_comb begin
        word_d    = word_q;
        lane_base = 0;
        if (msb_first_q) begin
            lane_base = WORD_SIZE - LANES * (int'(beat_q) + 1);
        end else begin
            lane_base = int'(beat_q) * LANES;
        end
        word_d[lane_base +: LANES] = rx_data;
    end

    // Space is reserved at the handshake: only one word is ever in flight.
    // The handshake is allowed only while the FIFO has room.
    assign m_ready   = (state_q == WAIT) && !fifo_full;
    assign fifo_push = (state_q == SHIFT) && last_beat;
    assign fifo_pop  = !fifo_empty && core_ready;

    // These are plain decodes of the registered state
    assign rx_done  = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign new_data = (fifo_count != '0);
    assign s_data   = fifo_empty ? hold_q : fifo_head;

    // Transaction controller: command latch, handshake, beat shifting, completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            beat_q       <= '0;
            msb_first_q  <= 1'b0;
            word_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instruction == INSTR_READ) begin
                        words_left_q <= BURST_W'(1);
                        msb_first_q  <= msb_first;
                        state_q      <= WAIT;
                    end else if (instruction == INSTR_BURST_READ) begin
                        words_left_q <= burst_size;
                        msb_first_q  <= msb_first;
                        state_q      <= (burst_size == '0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (m_ready && s_valid) begin
                        beat_q  <= '0;
                        word_q  <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    word_q <= word_d;
                    if (last_beat) begin
                        beat_q       <= '0;
                        words_left_q <= words_left_q - BURST_W'(1);
                        state_q      <= (words_left_q == BURST_W'(1)) ? DONE : WAIT;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Keep the most recent head word so s_data holds steady while the FIFO is empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (!fifo_empty) begin
            hold_q <= fifo_head;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (word_d),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule
